mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the MIPS core with architectural HI/LO registers.
//  - Consumes the two register-file read ports (rs/rt values) for MULT, MULTU, DIV and DIVU.
//  - HI/LO drive the MFHI/MFLO writeback path into the register file; MTHI/MTLO load them.
//  - Control stalls on busy; one operation is in flight at a time.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_div_step.sv | 32 +++
 rtl/mult_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   MDU_WIDTH  default operand / HI / LO width
//   ITER_W     iteration counter width, wide enough to hold MDU_WIDTH
//   mdu_op_e   operation codes presented on op
//   mdu_state_e controller state encoding
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int ITER_W    = $clog2(MDU_WIDTH + 1);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem_i      partial remainder before the step
//   quo_i      dividend bits still to be consumed (MSB first), quotient bits fill from the LSB
//   divisor_i  divisor magnitude
//   rem_o      partial remainder after the step
//   quo_o      shifted dividend/quotient word with the new quotient bit in the LSB
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           fits;

   // The remainder is always below the divisor, so the shifted value fits in
   // WIDTH+1 bits and the top bit of the trial difference is a clean borrow.
   assign shifted = {rem_i, quo_i[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor_i};
   assign fits    = ~trial[WIDTH];

   always_comb begin
      rem_o = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
//   clk     system clock, rising edge
//   rst_n   asynchronous reset, active low
//   start   launch an operation (honoured only in IDLE or DONE)
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  multiplicand / dividend
//   rt_val  multiplier / divisor
//   hi_we   MTHI write strobe (ignored while busy)
//   lo_we   MTLO write strobe (ignored while busy)
//   wdata   MTHI/MTLO data
//   busy    operation in progress
//   done    one-cycle pulse, HI/LO hold the new result
//   hi, lo  HI / LO registers
//
// state   | meaning
// --------+----------------------------------------------------
// ST_IDLE | no operation; HI/LO writable, start accepted
// ST_MUL  | shift-add multiply iterations
// ST_DIV  | restoring divide iterations
// ST_DONE | result just written; start accepted back-to-back
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_e         state_q, state_d;
   logic [ITER_W-1:0]  cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               idle_like;
   logic               last_iter;
   logic               signed_op;
   logic               rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic               div_zero;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_rem, div_quo;

   assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign last_iter = (cnt_q == ITER_W'(WIDTH - 1));

   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign rs_neg    = signed_op & rs_val[WIDTH-1];
   assign rt_neg    = signed_op & rt_val[WIDTH-1];
   assign rs_mag    = rs_neg ? -rs_val : rs_val;
   assign rt_mag    = rt_neg ? -rt_val : rt_val;
   assign div_zero  = (rt_val == '0);

   // Multiply: acc = {partial product, remaining multiplier bits}; add the
   // multiplicand into the upper half when the multiplier LSB is set, then
   // shift the whole accumulator right one place.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   assign prod_fix = neg_q ? -mul_next : mul_next;

   // Divide: acc = {partial remainder, dividend/quotient word}.
   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
      .quo_i     (acc_q[WIDTH-1:0]),
      .divisor_i (mcand_q),
      .rem_o     (div_rem),
      .quo_o     (div_quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = op[1] ? ST_DIV : ST_MUL;
            else       state_d = ST_IDLE;
         end
         ST_MUL, ST_DIV: begin
            if (last_iter) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_MUL) || (state_q == ST_DIV);
      done = (state_q == ST_DONE);
   end

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               cnt_d = '0;
               if (!op[1]) begin
                  acc_d   = {{WIDTH{1'b0}}, rt_mag};
                  mcand_d = rs_mag;
                  neg_d   = rs_neg ^ rt_neg;
                  rneg_d  = 1'b0;
               end else if (div_zero) begin
                  // Zero divisor: dividing the raw dividend by zero yields
                  // all-ones quotient and the raw dividend as remainder.
                  acc_d   = {{WIDTH{1'b0}}, rs_val};
                  mcand_d = '0;
                  neg_d   = 1'b0;
                  rneg_d  = 1'b0;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, rs_mag};
                  mcand_d = rt_mag;
                  neg_d   = rs_neg ^ rt_neg;
                  rneg_d  = rs_neg;
               end
            end
         end
         ST_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + ITER_W'(1);
            if (last_iter) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         ST_DIV: begin
            acc_d = {div_rem, div_quo};
            cnt_d = cnt_q + ITER_W'(1);
            if (last_iter) begin
               lo_d = neg_q  ? -div_quo : div_quo;
               hi_d = rneg_q ? -div_rem : div_rem;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_vec = 0;
   int n_fail = 0;

   mult_div_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result {HI, LO} from plain arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int     sa, sb, q, r;
      longint p;
      sa = a;
      sb = b;
      case (o)
         2'b00: begin
            p = longint'(sa) * longint'(sb);
            return p;
         end
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Cycle-level reference: an accepted start schedules its result 32 edges later.
   int          m_rem = 0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] m_pend = '0;
   bit          cmp_en = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               {m_hi, m_lo} = m_pend;
               m_done = 1'b1;
               m_busy = 1'b0;
            end
         end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start) begin
               m_pend = ref_result(op, rs_val, rt_val);
               m_rem  = 32;
               m_busy = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", {63'b0, busy}, {63'b0, m_busy});
         check("done", {63'b0, done}, {63'b0, m_done});
         check("hi", {32'b0, hi}, {32'b0, m_hi});
         check("lo", {32'b0, lo}, {32'b0, m_lo});
      end
   end

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, input int poke, output int lat, output int bcnt);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      lat = -1; bcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            break;
         end
         if (busy) bcnt++;
         if (i == poke) begin
            start = 1'b1; rs_val = 32'd9; hi_we = 1'b1; wdata = 32'h0000_DEAD;
         end else if (noise) begin
            start  = 1'($urandom_range(0, 1));
            hi_we  = 1'($urandom_range(0, 1));
            lo_we  = 1'($urandom_range(0, 1));
            wdata  = $urandom;
            op     = 2'($urandom_range(0, 3));
            rs_val = $urandom;
            rt_val = $urandom;
         end else begin
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         end
      end
      if (lat < 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL timeout: done not seen within 40 cycles, op=%0d", o);
         start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] sp [5];
      sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      int lat, bcnt, extra;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int g;

      #1;
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      check("pin_mult",  ref_result(2'b00, 32'hFFFF_FFFD, 32'd7), {32'hFFFF_FFFF, 32'hFFFF_FFEB});
      check("pin_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {32'hFFFF_FFFE, 32'h0000_0001});
      check("pin_div",   ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      check("pin_divu",  ref_result(2'b11, 32'd100, 32'd7), {32'd2, 32'd14});

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat, bcnt);
      check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
      check("latency", 64'(lat), 64'd33);
      check("busy_len", 64'(bcnt), 64'd32);

      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, lat, bcnt);
      check("mult_b2b", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
      check("b2b_latency", 64'(lat), 64'd33);

      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, lat, bcnt);
      check("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      @(negedge clk);
      run_op(2'b11, 32'd100, 32'd7, 1'b0, 0, lat, bcnt);
      check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

      @(negedge clk);
      run_op(2'b11, 32'd5, 32'd0, 1'b0, 0, lat, bcnt);
      check("divu_by0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 0, lat, bcnt);
      check("div_neg_by0", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat, bcnt);
      check("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});

      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h0000_AAAA;
      run_op(2'b01, 32'd2, 32'd3, 1'b0, 0, lat, bcnt);
      check("we_with_start", {hi, lo}, {32'd0, 32'd6});

      @(negedge clk);
      run_op(2'b01, 32'd3, 32'd4, 1'b0, 5, lat, bcnt);
      check("multu_poke", {hi, lo}, {32'd0, 32'd12});
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("done_once", 64'(extra), 64'd0);
      lo_we = 1'b1; wdata = 32'h0000_1234;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo", {32'b0, lo}, {32'b0, 32'h0000_1234});

      op = 2'b11; rs_val = 32'd1000; rt_val = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", {63'b0, busy}, 64'd0);
      check("arst_done", {63'b0, done}, 64'd0);
      check("arst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      run_op(2'b11, 32'd9, 32'd3, 1'b0, 0, lat, bcnt);
      check("divu_after_rst", {hi, lo}, {32'd0, 32'd3});

      for (int k = 0; k < 50; k++) begin
         g = $urandom_range(0, 2);
         repeat (g) begin
            hi_we = 1'($urandom_range(0, 1));
            lo_we = 1'($urandom_range(0, 1));
            wdata = $urandom;
            @(negedge clk);
         end
         hi_we = 1'($urandom_range(0, 1));
         lo_we = 1'b0;
         wdata = $urandom;
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         run_op(ro, ra, rb, 1'b1, 0, lat, bcnt);
         check("rand_result", {hi, lo}, ref_result(ro, ra, rb));
      end

      @(negedge clk);
      @(negedge clk);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
